// File: rtl/ram_arb_pkg.sv
// Shared types and defaults for the data-RAM arbiter.
// Optional debug aging is enabled with RAM_ARB_AGE_EN.
package ram_arb_pkg;

    localparam int AW_DEF = 12;
    localparam int DW_DEF = 4;
    localparam int MAX_WAIT_DEF = 8;

    typedef enum logic {
        OWN_CPU,
        OWN_DBG
    } owner_t;

    typedef enum logic {
        ST_NORMAL,
        ST_LOCKED
    } arb_state_t;

    function automatic owner_t grant_owner(input logic i_cpuGnt);
        return i_cpuGnt ? OWN_CPU : OWN_DBG;
    endfunction

endpackage

// File: rtl/ram_arb_age_cnt.sv
// Debug starvation counter; raises o_ageWin after MAX_WAIT lost cycles.
// Built only when RAM_ARB_AGE_EN is defined.
module ram_arb_age_cnt
    import ram_arb_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic i_clk,
    input  logic i_rstN,
    input  logic i_dbgReq,
    input  logic i_dbgGnt,
    output logic o_ageWin
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] r_waitCnt;

    // Count never passes MAX_WAIT: at the limit debug is always granted.
    always_ff @(posedge i_clk or negedge i_rstN) begin
        if (!i_rstN) begin
            r_waitCnt <= '0;
        end else if (!i_dbgReq || i_dbgGnt) begin
            r_waitCnt <= '0;
        end else begin
            r_waitCnt <= r_waitCnt + 1'b1;
        end
    end

    assign o_ageWin = (r_waitCnt == CW'(MAX_WAIT));

endmodule

// File: rtl/ram_arbiter.sv
// Single-port data RAM arbiter between CPU and debug/loader port.
// Define RAM_ARB_AGE_EN to let starved debug requests win a conflict.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rstN,
    input  logic          cpuReq,
    input  logic          cpuWe,
    input  logic [AW-1:0] cpuAddr,
    input  logic [DW-1:0] cpuWdata,
    output logic          cpuGnt,
    output logic          cpuRvalid,
    output logic [DW-1:0] cpuRdata,
    input  logic          dbgReq,
    input  logic          dbgWe,
    input  logic [AW-1:0] dbgAddr,
    input  logic [DW-1:0] dbgWdata,
    output logic          dbgGnt,
    output logic          dbgRvalid,
    output logic [DW-1:0] dbgRdata,
    input  logic          dbgLock,
    output logic          lockAck,
    output logic          ramWe,
    output logic          ramRe,
    output logic [AW-1:0] ramAddr,
    output logic [DW-1:0] ramDataIn,
    input  logic [DW-1:0] ramDataOut
);

    arb_state_t r_state;
    arb_state_t w_stateNxt;
    logic       r_respValid;
    owner_t     r_respOwner;

    logic w_ageWin;
    logic w_cpuGnt;
    logic w_dbgGnt;
    logic w_rdIssue;
    logic w_cpuRv;
    logic w_dbgRv;

`ifdef RAM_ARB_AGE_EN
    ram_arb_age_cnt #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age_cnt (
        .i_clk    (clk),
        .i_rstN   (rstN),
        .i_dbgReq (dbgReq),
        .i_dbgGnt (w_dbgGnt),
        .o_ageWin (w_ageWin)
    );
`else
    assign w_ageWin = 1'b0;
`endif

    // Grants are gated by rstN so nothing leaks out during reset.
    assign w_cpuGnt = rstN & cpuReq & ~dbgLock
                    & (r_state == ST_NORMAL) & ~w_ageWin;
    assign w_dbgGnt = rstN & dbgReq & ~w_cpuGnt;

    assign cpuGnt = w_cpuGnt;
    assign dbgGnt = w_dbgGnt;

    always_comb begin
        ramWe     = 1'b0;
        ramRe     = 1'b0;
        ramAddr   = '0;
        ramDataIn = '0;
        if (w_cpuGnt) begin
            ramWe     = cpuWe;
            ramRe     = ~cpuWe;
            ramAddr   = cpuAddr;
            ramDataIn = cpuWdata;
        end else if (w_dbgGnt) begin
            ramWe     = dbgWe;
            ramRe     = ~dbgWe;
            ramAddr   = dbgAddr;
            ramDataIn = dbgWdata;
        end
    end

    always_comb begin
        w_stateNxt = r_state;
        unique case (r_state)
            ST_NORMAL: if (dbgLock) w_stateNxt = ST_LOCKED;
            ST_LOCKED: if (!dbgLock) w_stateNxt = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    assign w_rdIssue = (w_cpuGnt & ~cpuWe) | (w_dbgGnt & ~dbgWe);

    // Tracks the single read whose data appears on ramDataOut next cycle.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_respValid <= 1'b0;
            r_respOwner <= OWN_CPU;
        end else begin
            r_respValid <= w_rdIssue;
            if (w_rdIssue) begin
                r_respOwner <= grant_owner(w_cpuGnt);
            end
        end
    end

    assign w_cpuRv = rstN & r_respValid & (r_respOwner == OWN_CPU);
    assign w_dbgRv = rstN & r_respValid & (r_respOwner == OWN_DBG);

    assign cpuRvalid = w_cpuRv;
    assign dbgRvalid = w_dbgRv;
    assign cpuRdata  = w_cpuRv ? ramDataOut : '0;
    assign dbgRdata  = w_dbgRv ? ramDataOut : '0;

    assign lockAck = rstN & (r_state == ST_LOCKED)
                   & ~(r_respValid & (r_respOwner == OWN_CPU));

endmodule
